// File: rtl/s38584_qual_status_bank.sv
// s38584_qual_status_bank: bank of NUM_CH independent status bits. A bit is set
// after arm/pattern/key qualification holds for QUAL_CYCLES consecutive
// enabled cycles, and is cleared by clr_req or, in level mode, by loss of
// qualification. en=0 freezes the whole bank.
module s38584_qual_status_bank #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      PAT_W       = 8,
    parameter logic [PAT_W-1:0] PAT_VALUE   = 8'hA5,
    parameter logic [PAT_W-1:0] PAT_MASK    = 8'hFF,
    parameter int unsigned      KEY_W       = 2,
    parameter int unsigned      QUAL_CYCLES = 3,
    parameter bit               STICKY      = 1'b1
) (
    input  logic                      CK,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         arm_req,
    input  logic [NUM_CH-1:0]         clr_req,
    input  logic [NUM_CH*PAT_W-1:0]   pat_in,
    input  logic [NUM_CH*KEY_W-1:0]   key_a,
    input  logic [NUM_CH*KEY_W-1:0]   key_b,
    output logic [NUM_CH-1:0]         status_q,
    output logic [NUM_CH-1:0]         set_pulse,
    output logic                      any_set
);

    localparam int unsigned CW = $clog2(QUAL_CYCLES + 1);
    localparam logic [CW:0] QC = (CW+1)'(QUAL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_SET  = 2'd2
    } state_t;

    state_t                   r_state [NUM_CH];
    logic [NUM_CH-1:0][CW-1:0] r_cnt;
    logic [NUM_CH-1:0]        r_status;
    logic [NUM_CH-1:0]        r_pulse;
    logic                     r_any;

    state_t                   w_nstate [NUM_CH];
    logic [NUM_CH-1:0][CW-1:0] w_ncnt;
    logic [NUM_CH-1:0][CW:0]   w_inc;
    logic [NUM_CH-1:0]        w_pat_ok;
    logic [NUM_CH-1:0]        w_key_ok;
    logic [NUM_CH-1:0]        w_qual;
    logic [NUM_CH-1:0]        w_nstatus;
    logic [NUM_CH-1:0]        w_npulse;

    // Per-channel qualification terms and next-state/counter decode
    always_comb begin
        w_pat_ok  = '0;
        w_key_ok  = '0;
        w_qual    = '0;
        w_nstatus = '0;
        w_npulse  = '0;
        w_ncnt    = '0;
        w_inc     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_nstate[i] = ST_IDLE;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_pat_ok[i] = (((pat_in[i*PAT_W +: PAT_W] ^ PAT_VALUE) & PAT_MASK) == '0);
            w_key_ok[i] = (key_a[i*KEY_W +: KEY_W] == key_b[i*KEY_W +: KEY_W]);
            w_qual[i]   = arm_req[i] & w_pat_ok[i] & w_key_ok[i];
            w_inc[i]    = {1'b0, r_cnt[i]} + (CW+1)'(1);
            case (r_state[i])
                ST_IDLE: begin
                    if (!clr_req[i] && w_qual[i]) begin
                        w_ncnt[i]   = CW'(1);
                        w_nstate[i] = (QUAL_CYCLES == 1) ? ST_SET : ST_QUAL;
                    end
                end
                ST_QUAL: begin
                    if (!clr_req[i] && w_qual[i]) begin
                        w_ncnt[i]   = w_inc[i][CW-1:0];
                        w_nstate[i] = (w_inc[i] == QC) ? ST_SET : ST_QUAL;
                    end
                end
                ST_SET: begin
                    // clear wins over qual; level mode also drops on lost qual
                    if (!clr_req[i] && (STICKY || w_qual[i])) begin
                        w_ncnt[i]   = QC[CW-1:0];
                        w_nstate[i] = ST_SET;
                    end
                end
                default: begin
                    w_nstate[i] = ST_IDLE;
                end
            endcase
            w_nstatus[i] = (w_nstate[i] == ST_SET);
            w_npulse[i]  = (w_nstate[i] == ST_SET) && (r_state[i] != ST_SET);
        end
    end

    // State, counters and registered outputs; en=0 holds all but set_pulse
    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
            end
            r_cnt    <= '0;
            r_status <= '0;
            r_pulse  <= '0;
            r_any    <= 1'b0;
        end else if (en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_nstate[i];
            end
            r_cnt    <= w_ncnt;
            r_status <= w_nstatus;
            r_pulse  <= w_npulse;
            r_any    <= |w_nstatus;
        end else begin
            r_pulse  <= '0;
        end
    end

    assign status_q  = r_status;
    assign set_pulse = r_pulse;
    assign any_set   = r_any;

endmodule

// File: tb/tb_s38584_qual_status_bank.sv
// Directed bench for s38584_qual_status_bank: default build plus a level-mode
// build and a single-cycle-qualification build sharing the same stimulus.
module tb_s38584_qual_status_bank;

    logic        CK;
    logic        rst_n;
    logic        en;
    logic [3:0]  arm_req;
    logic [3:0]  clr_req;
    logic [31:0] pat_in;
    logic [7:0]  key_a;
    logic [7:0]  key_b;

    logic [3:0]  status_q,  set_pulse;
    logic        any_set;
    logic [3:0]  ns_status, ns_pulse;
    logic        ns_any;
    logic [3:0]  q1_status, q1_pulse;
    logic        q1_any;

    int checks   = 0;
    int failures = 0;

    s38584_qual_status_bank dut (
        .CK(CK), .rst_n(rst_n), .en(en), .arm_req(arm_req), .clr_req(clr_req),
        .pat_in(pat_in), .key_a(key_a), .key_b(key_b),
        .status_q(status_q), .set_pulse(set_pulse), .any_set(any_set)
    );

    s38584_qual_status_bank #(.STICKY(1'b0)) dut_ns (
        .CK(CK), .rst_n(rst_n), .en(en), .arm_req(arm_req), .clr_req(clr_req),
        .pat_in(pat_in), .key_a(key_a), .key_b(key_b),
        .status_q(ns_status), .set_pulse(ns_pulse), .any_set(ns_any)
    );

    s38584_qual_status_bank #(.QUAL_CYCLES(1)) dut_q1 (
        .CK(CK), .rst_n(rst_n), .en(en), .arm_req(arm_req), .clr_req(clr_req),
        .pat_in(pat_in), .key_a(key_a), .key_b(key_b),
        .status_q(q1_status), .set_pulse(q1_pulse), .any_set(q1_any)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic set_ch(input int ch, input logic arm, input logic [7:0] pat,
                          input logic [1:0] ka, input logic [1:0] kb);
        arm_req[ch]        = arm;
        pat_in[ch*8 +: 8]  = pat;
        key_a[ch*2 +: 2]   = ka;
        key_b[ch*2 +: 2]   = kb;
    endtask

    task automatic do_reset();
        en      = 1'b1;
        arm_req = '0;
        clr_req = '0;
        pat_in  = '0;
        key_a   = '0;
        key_b   = 8'hFF;
        rst_n   = 1'b0;
        @(negedge CK);
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; arm_req = '0; clr_req = '0; pat_in = '0; key_a = '0; key_b = '0;
        rst_n = 1'b0;
        #12;
        checks++; if (status_q !== 4'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", status_q); end
        checks++; if (set_pulse !== 4'h0) begin failures++; $display("FAIL reset_pulse got=%h exp=0", set_pulse); end
        checks++; if (any_set !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", any_set); end
        @(negedge CK);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        set_ch(0, 1'b1, 8'hA5, 2'b10, 2'b10);
        step(); step();
        checks++; if (status_q !== 4'h0) begin failures++; $display("FAIL basic_edge2 got=%h exp=0", status_q); end
        checks++; if (any_set !== 1'b0) begin failures++; $display("FAIL basic_any_edge2 got=%b exp=0", any_set); end
        step();
        checks++; if (status_q !== 4'h1) begin failures++; $display("FAIL basic_edge3 got=%h exp=1", status_q); end
        checks++; if (set_pulse !== 4'h1) begin failures++; $display("FAIL basic_pulse got=%h exp=1", set_pulse); end
        checks++; if (any_set !== 1'b1) begin failures++; $display("FAIL basic_any got=%b exp=1", any_set); end
        step();
        checks++; if (set_pulse !== 4'h0) begin failures++; $display("FAIL basic_pulse_drop got=%h exp=0", set_pulse); end
        checks++; if (status_q !== 4'h1) begin failures++; $display("FAIL basic_hold got=%h exp=1", status_q); end
    endtask

    task automatic test_pat_break();
        do_reset();
        set_ch(0, 1'b1, 8'hA5, 2'b10, 2'b10);
        step();
        pat_in[7:0] = 8'hA4;
        step();
        pat_in[7:0] = 8'hA5;
        step(); step();
        checks++; if (status_q[0] !== 1'b0) begin failures++; $display("FAIL pat_break_restart got=%b exp=0", status_q[0]); end
        step();
        checks++; if (status_q[0] !== 1'b1) begin failures++; $display("FAIL pat_break_set got=%b exp=1", status_q[0]); end
    endtask

    task automatic test_en_freeze();
        do_reset();
        set_ch(0, 1'b1, 8'hA5, 2'b10, 2'b10);
        step(); step();
        en = 1'b0;
        step();
        checks++; if (status_q[0] !== 1'b0) begin failures++; $display("FAIL en_freeze1 got=%b exp=0", status_q[0]); end
        step();
        checks++; if (status_q[0] !== 1'b0) begin failures++; $display("FAIL en_freeze2 got=%b exp=0", status_q[0]); end
        en = 1'b1;
        step();
        checks++; if (status_q[0] !== 1'b1) begin failures++; $display("FAIL en_resume got=%b exp=1", status_q[0]); end
        checks++; if (set_pulse[0] !== 1'b1) begin failures++; $display("FAIL en_resume_pulse got=%b exp=1", set_pulse[0]); end
        en = 1'b0;
        clr_req[0] = 1'b1;
        step();
        checks++; if (set_pulse[0] !== 1'b0) begin failures++; $display("FAIL en_pulse_force got=%b exp=0", set_pulse[0]); end
        checks++; if (status_q[0] !== 1'b1) begin failures++; $display("FAIL en_clr_frozen got=%b exp=1", status_q[0]); end
        en = 1'b1;
        clr_req[0] = 1'b0;
    endtask

    task automatic test_clr_priority();
        do_reset();
        set_ch(1, 1'b1, 8'hA5, 2'b01, 2'b01);
        step(); step(); step();
        checks++; if (status_q !== 4'h2) begin failures++; $display("FAIL clr_pre_set got=%h exp=2", status_q); end
        clr_req[1] = 1'b1;
        step();
        checks++; if (status_q[1] !== 1'b0) begin failures++; $display("FAIL clr_priority got=%b exp=0", status_q[1]); end
        checks++; if (any_set !== 1'b0) begin failures++; $display("FAIL clr_any got=%b exp=0", any_set); end
        clr_req[1] = 1'b0;
        step(); step();
        checks++; if (status_q[1] !== 1'b0) begin failures++; $display("FAIL clr_requal_early got=%b exp=0", status_q[1]); end
        step();
        checks++; if (status_q[1] !== 1'b1) begin failures++; $display("FAIL clr_requal got=%b exp=1", status_q[1]); end
        checks++; if (set_pulse !== 4'h2) begin failures++; $display("FAIL clr_requal_pulse got=%h exp=2", set_pulse); end
    endtask

    task automatic test_level_mode();
        do_reset();
        set_ch(2, 1'b1, 8'hA5, 2'b11, 2'b11);
        step(); step(); step();
        checks++; if (ns_status !== 4'h4) begin failures++; $display("FAIL level_set got=%h exp=4", ns_status); end
        key_b[5:4] = 2'b00;
        step();
        checks++; if (ns_status[2] !== 1'b0) begin failures++; $display("FAIL level_drop got=%b exp=0", ns_status[2]); end
        checks++; if (ns_any !== 1'b0) begin failures++; $display("FAIL level_any got=%b exp=0", ns_any); end
        checks++; if (status_q[2] !== 1'b1) begin failures++; $display("FAIL sticky_hold got=%b exp=1", status_q[2]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_ch(0, 1'b1, 8'hA5, 2'b10, 2'b10);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (status_q !== 4'h0) begin failures++; $display("FAIL async_set_status got=%h exp=0", status_q); end
        checks++; if (any_set !== 1'b0) begin failures++; $display("FAIL async_set_any got=%b exp=0", any_set); end
        @(negedge CK);
        rst_n = 1'b1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (status_q !== 4'h0) begin failures++; $display("FAIL async_qual_status got=%h exp=0", status_q); end
        @(negedge CK);
        rst_n = 1'b1;
        step(); step();
        checks++; if (status_q[0] !== 1'b0) begin failures++; $display("FAIL async_restart got=%b exp=0", status_q[0]); end
        step();
        checks++; if (status_q[0] !== 1'b1) begin failures++; $display("FAIL async_requal got=%b exp=1", status_q[0]); end
    endtask

    task automatic test_qual_one();
        do_reset();
        set_ch(3, 1'b1, 8'hA5, 2'b00, 2'b00);
        step();
        checks++; if (q1_status !== 4'h8) begin failures++; $display("FAIL q1_set got=%h exp=8", q1_status); end
        checks++; if (q1_pulse !== 4'h8) begin failures++; $display("FAIL q1_pulse got=%h exp=8", q1_pulse); end
        checks++; if (q1_any !== 1'b1) begin failures++; $display("FAIL q1_any got=%b exp=1", q1_any); end
        checks++; if (status_q[3] !== 1'b0) begin failures++; $display("FAIL q3_not_yet got=%b exp=0", status_q[3]); end
    endtask

    task automatic test_independent();
        do_reset();
        set_ch(0, 1'b1, 8'hA5, 2'b10, 2'b10);
        set_ch(1, 1'b0, 8'hA5, 2'b10, 2'b10);
        set_ch(2, 1'b1, 8'h5A, 2'b10, 2'b10);
        set_ch(3, 1'b1, 8'hA5, 2'b10, 2'b01);
        step(); step(); step();
        checks++; if (status_q !== 4'h1) begin failures++; $display("FAIL indep_status got=%h exp=1", status_q); end
        checks++; if (q1_status !== 4'h1) begin failures++; $display("FAIL indep_q1 got=%h exp=1", q1_status); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pat_break();
        test_en_freeze();
        test_clr_priority();
        test_level_mode();
        test_async_reset();
        test_qual_one();
        test_independent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
